mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
Target-side endpoint of the 128-bit memory request interface driven by the IP's memory controller port (addr/wdata/write-enable/read-enable/ready/rdata). Accepts one write or read per handshake into an internal word array, models a programmable access latency, and returns read data with a valid strobe. Keeps transaction and protocol-error counters for integration benches and FPGA bring-up, where it stands in for the real memory.

Parameters:
DEPTH, 256, number of 128-bit words stored (power of two, 2..4096)
LATENCY, 2, busy cycles between acceptance and response (1..15)
ADDR_LSB, 4, byte-address bits dropped to form the word index (16-byte words)

Ports:
clk_main_200mhz  input  1  clock; all logic rising-edge
reset_n  input  1  asynchronous active-low reset
mem_addr_bus  input  32  byte address of the request
mem_write_data  input  128  write data
mem_write_enable  input  1  write request, level, sampled when mem_ready=1
mem_read_enable  input  1  read request, level, sampled when mem_ready=1
mem_ready  output  1  responder can accept a request this cycle
mem_read_data  output  128  read data; held until the next read response
mem_read_valid  output  1  one-cycle strobe, mem_read_data valid
wr_count  output  32  accepted writes, wraps modulo 2^32
rd_count  output  32  accepted reads, wraps modulo 2^32
err_count  output  16  protocol/address errors, saturates at 0xFFFF
addr_error  output  1  sticky: an out-of-range access has occurred

Behaviour:
- Reset: async assert, sync deassert handled upstream. State IDLE, mem_ready=1, mem_read_valid=0, mem_read_data=0, all counters=0, addr_error=0. Storage contents are not reset and are undefined until written.
- Word index = mem_addr_bus[ADDR_LSB+log2(DEPTH)-1 : ADDR_LSB]. The access is out of range if any of mem_addr_bus[31 : ADDR_LSB+log2(DEPTH)] is nonzero. Low ADDR_LSB bits are ignored.
- Acceptance: on a rising edge with state IDLE and (mem_write_enable | mem_read_enable). Request signals are ignored while mem_ready=0.
- Both enables high at acceptance: treated as a write only; read is discarded; err_count += 1.
- Write: storage updated at the acceptance edge (in range only); wr_count += 1. Out-of-range write: no storage change, err_count += 1, addr_error set.
- Read: index captured at acceptance; rd_count += 1. Out-of-range read returns 0, err_count += 1, addr_error set.
- FSM states are IDLE, BUSY and RESP.
  - IDLE: mem_ready=1; goes to BUSY on acceptance, loading cnt=LATENCY-1.
  - BUSY: mem_ready=0; cnt decrements; goes to RESP when cnt==0.
  - RESP: mem_ready=0; if the op was a read, mem_read_data is updated and mem_read_valid=1 this cycle only; next state is IDLE.
- Timing (cycle 0 = acceptance cycle): cycles 1..LATENCY are BUSY, cycle LATENCY+1 is RESP, cycle LATENCY+2 is IDLE. Sustained throughput is one request per LATENCY+2 cycles.
- A write to the address a pending read targets cannot occur, because the interface is blocked while busy.
- mem_read_data keeps its last value across writes and idle cycles.
- err_count saturates, with no wrap. wr_count and rd_count wrap from 0xFFFFFFFF to 0.
- Reset mid-transaction: the pending response is dropped, and the FSM returns to IDLE. A write already accepted before reset may remain in storage.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Package mem_responder_pkg:
  - state enum {IDLE, BUSY, RESP};
  - WORD_W=128, ADDR_W=32;
  - counter widths (32, 16);
  - ERR_SAT=16'hFFFF.
- Sub-module mem_responder_ram: single-port synchronous RAM, DEPTH x 128, write-enable and registered read. Read is issued at acceptance, and the result is captured into mem_read_data in RESP.
- The top level holds the FSM, latency counter, range check, error logic and counters.

Test Plan:
- Reset check: assert reset_n=0 -> mem_ready=1, mem_read_valid=0, mem_read_data=0, all counters 0, addr_error=0.
- Write then read (LATENCY=2):
  - Write addr 0x0000_0010, data 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_F0F0 -> mem_ready low in cycles 1-3, high in cycle 4.
  - Read addr 0x0000_0010 -> mem_read_valid high exactly in cycle 3 with that data; wr_count=1, rd_count=1.
- Simultaneous enables: both enables high, addr 0x20, data 128'h1 -> write stored, no read_valid pulse, err_count=1; read of 0x20 later returns 128'h1.
- Out of range (DEPTH=256): read addr 0x0000_1000 -> mem_read_valid pulse with data 0, addr_error=1, err_count+1. Write addr 0xFFFF_FFF0 -> storage unchanged (verified by readback of index 255).
- Ready-gated stimulus: hold mem_read_enable high continuously for 20 cycles at LATENCY=2 -> exactly 5 reads accepted (one per 4 cycles), rd_count=5.
- Reset mid-read and saturation:
  - Deassert reset_n in cycle 1 of a read -> no mem_read_valid pulse, mem_ready=1 after release.
  - Force err_count near saturation via 0xFFFF+3 errors -> err_count holds 0xFFFF.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared types and widths for the memory responder endpoint.
package mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int WORD_W  = 128;
    localparam int ADDR_W  = 32;
    localparam int TXN_W   = 32;
    localparam int ERR_W   = 16;
    localparam logic [ERR_W-1:0] ERR_SAT = 16'hFFFF;

endpackage

// File: rtl/mem_responder_ram.sv
// Single-port word store with write enable and registered read; contents are not reset.
module mem_responder_ram
    import mem_responder_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk_main_200mhz,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic [WORD_W-1:0] i_wdata,
    output logic [WORD_W-1:0] o_rdata
);

    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [WORD_W-1:0] r_rdata;

    always_ff @(posedge clk_main_200mhz) begin
        if (i_we) r_mem[i_idx] <= i_wdata;
        if (i_re) r_rdata <= r_mem[i_idx];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Memory-interface target: accepts one request per handshake, waits LATENCY cycles,
// then answers reads; tracks write/read/error counters for bring-up.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DEPTH    = 256,
    parameter int LATENCY  = 2,
    parameter int ADDR_LSB = 4
) (
    input  logic              clk_main_200mhz,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] mem_addr_bus,
    input  logic [WORD_W-1:0] mem_write_data,
    input  logic              mem_write_enable,
    input  logic              mem_read_enable,
    output logic              mem_ready,
    output logic [WORD_W-1:0] mem_read_data,
    output logic              mem_read_valid,
    output logic [TXN_W-1:0]  wr_count,
    output logic [TXN_W-1:0]  rd_count,
    output logic [ERR_W-1:0]  err_count,
    output logic              addr_error
);

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int HI_LSB = ADDR_LSB + IDX_W;

    state_t            r_state;
    state_t            w_state_next;
    logic [3:0]        r_cnt;
    logic              r_op_read;
    logic              r_op_oor;
    logic              r_ready;
    logic              r_valid;
    logic [WORD_W-1:0] r_rdata;
    logic [TXN_W-1:0]  r_wr_count;
    logic [TXN_W-1:0]  r_rd_count;
    logic [ERR_W-1:0]  r_err_count;
    logic              r_addr_error;

    logic              w_accept;
    logic              w_oor;
    logic [IDX_W-1:0]  w_idx;
    logic              w_is_read;
    logic [1:0]        w_err_inc;
    logic [ERR_W:0]    w_err_sum;
    logic [ERR_W-1:0]  w_err_next;
    logic [WORD_W-1:0] w_ram_rdata;
    logic              w_resp_load;
    logic              w_unused_lsb;

    assign w_accept  = (r_state == IDLE) && (mem_write_enable || mem_read_enable);
    assign w_oor     = |mem_addr_bus[ADDR_W-1:HI_LSB];
    assign w_idx     = mem_addr_bus[ADDR_LSB +: IDX_W];
    assign w_is_read = mem_read_enable && !mem_write_enable;
    assign w_unused_lsb = ^mem_addr_bus[ADDR_LSB-1:0];

    // A request with both enables and a bad address costs two errors.
    assign w_err_inc  = {1'b0, w_accept && mem_write_enable && mem_read_enable}
                      + {1'b0, w_accept && w_oor};
    assign w_err_sum  = {1'b0, r_err_count} + {{(ERR_W-1){1'b0}}, w_err_inc};
    assign w_err_next = w_err_sum[ERR_W] ? ERR_SAT : w_err_sum[ERR_W-1:0];

    assign w_resp_load = (r_state == BUSY) && (w_state_next == RESP);

    mem_responder_ram #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk_main_200mhz (clk_main_200mhz),
        .i_we            (w_accept && mem_write_enable && !w_oor),
        .i_re            (w_accept && w_is_read && !w_oor),
        .i_idx           (w_idx),
        .i_wdata         (mem_write_data),
        .o_rdata         (w_ram_rdata)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = BUSY;
            BUSY:    if (r_cnt == 4'd0) w_state_next = RESP;
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_main_200mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_cnt        <= 4'd0;
            r_op_read    <= 1'b0;
            r_op_oor     <= 1'b0;
            r_ready      <= 1'b1;
            r_valid      <= 1'b0;
            r_rdata      <= '0;
            r_wr_count   <= '0;
            r_rd_count   <= '0;
            r_err_count  <= '0;
            r_addr_error <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_ready     <= (w_state_next == IDLE);
            r_valid     <= w_resp_load && r_op_read;
            r_err_count <= w_err_next;
            if (w_accept) begin
                r_cnt     <= 4'(LATENCY - 1);
                r_op_read <= w_is_read;
                r_op_oor  <= w_oor;
            end else if (r_state == BUSY && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_resp_load && r_op_read)
                r_rdata <= r_op_oor ? '0 : w_ram_rdata;
            if (w_accept && mem_write_enable) r_wr_count <= r_wr_count + 1'b1;
            if (w_accept && w_is_read)        r_rd_count <= r_rd_count + 1'b1;
            if (w_accept && w_oor)            r_addr_error <= 1'b1;
        end
    end

    assign mem_ready      = r_ready;
    assign mem_read_valid = r_valid;
    assign mem_read_data  = r_rdata;
    assign wr_count       = r_wr_count;
    assign rd_count       = r_rd_count;
    assign err_count      = r_err_count;
    assign addr_error     = r_addr_error;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder at DEPTH=256, LATENCY=2, ADDR_LSB=4.
module tb_mem_responder;

    logic         clk_main_200mhz = 1'b0;
    logic         reset_n;
    logic [31:0]  mem_addr_bus;
    logic [127:0] mem_write_data;
    logic         mem_write_enable;
    logic         mem_read_enable;
    logic         mem_ready;
    logic [127:0] mem_read_data;
    logic         mem_read_valid;
    logic [31:0]  wr_count;
    logic [31:0]  rd_count;
    logic [15:0]  err_count;
    logic         addr_error;

    localparam logic [127:0] D_A = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_F0F0;
    localparam logic [127:0] D_B = 128'h5555_AAAA_5555_AAAA_1234_5678_9ABC_DEF0;
    localparam logic [127:0] D_C = 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000;

    int           n_checks = 0;
    int           n_errors = 0;
    int           n_valid;
    int           v_cyc;
    logic [127:0] v_data;
    logic [3:0]   rdy_trace;
    int           pulses;
    logic [31:0]  rd_base;

    always #5 clk_main_200mhz = ~clk_main_200mhz;

    mem_responder #(
        .DEPTH    (256),
        .LATENCY  (2),
        .ADDR_LSB (4)
    ) dut (
        .clk_main_200mhz  (clk_main_200mhz),
        .reset_n          (reset_n),
        .mem_addr_bus     (mem_addr_bus),
        .mem_write_data   (mem_write_data),
        .mem_write_enable (mem_write_enable),
        .mem_read_enable  (mem_read_enable),
        .mem_ready        (mem_ready),
        .mem_read_data    (mem_read_data),
        .mem_read_valid   (mem_read_valid),
        .wr_count         (wr_count),
        .rd_count         (rd_count),
        .err_count        (err_count),
        .addr_error       (addr_error)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Starts at a negedge; returns at the negedge of cycle 4 with ready/valid observed per cycle.
    task automatic run_txn(input logic t_we, input logic t_re,
                           input logic [31:0] t_addr, input logic [127:0] t_data);
        int guard = 0;
        while (!mem_ready && guard < 20) begin
            @(negedge clk_main_200mhz);
            guard++;
        end
        if (guard >= 20) chk("ready_timeout", 128'(mem_ready), 128'd1);
        mem_write_enable = t_we;
        mem_read_enable  = t_re;
        mem_addr_bus     = t_addr;
        mem_write_data   = t_data;
        @(posedge clk_main_200mhz);
        #1;
        mem_write_enable = 1'b0;
        mem_read_enable  = 1'b0;
        n_valid   = 0;
        v_cyc     = 0;
        v_data    = '0;
        rdy_trace = '0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk_main_200mhz);
            rdy_trace[c-1] = mem_ready;
            if (mem_read_valid) begin
                n_valid++;
                v_cyc  = c;
                v_data = mem_read_data;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n          = 1'b0;
        mem_addr_bus     = '0;
        mem_write_data   = '0;
        mem_write_enable = 1'b0;
        mem_read_enable  = 1'b0;
        repeat (3) @(negedge clk_main_200mhz);

        chk("rst_ready",   128'(mem_ready), 128'd1);
        chk("rst_valid",   128'(mem_read_valid), 128'd0);
        chk("rst_rdata",   mem_read_data, 128'd0);
        chk("rst_wr",      128'(wr_count), 128'd0);
        chk("rst_rd",      128'(rd_count), 128'd0);
        chk("rst_err",     128'(err_count), 128'd0);
        chk("rst_addrerr", 128'(addr_error), 128'd0);

        reset_n = 1'b1;
        @(negedge clk_main_200mhz);

        // write then read back
        run_txn(1'b1, 1'b0, 32'h0000_0010, D_A);
        chk("wr_ready_trace", 128'(rdy_trace), 128'b1000);
        chk("wr_no_valid",    128'(n_valid), 128'd0);
        chk("wr_count1",      128'(wr_count), 128'd1);

        run_txn(1'b0, 1'b1, 32'h0000_0010, '0);
        chk("rd_ready_trace", 128'(rdy_trace), 128'b1000);
        chk("rd_one_pulse",   128'(n_valid), 128'd1);
        chk("rd_pulse_cycle", 128'(v_cyc), 128'd3);
        chk("rd_data",        v_data, D_A);
        chk("rd_count1",      128'(rd_count), 128'd1);
        chk("rd_wr_count1",   128'(wr_count), 128'd1);

        // both enables: write only, one error
        run_txn(1'b1, 1'b1, 32'h0000_0020, 128'h1);
        chk("both_no_valid", 128'(n_valid), 128'd0);
        chk("both_err",      128'(err_count), 128'd1);
        chk("both_wr",       128'(wr_count), 128'd2);
        chk("both_rd",       128'(rd_count), 128'd1);
        chk("both_rdata_hold", mem_read_data, D_A);
        run_txn(1'b0, 1'b1, 32'h0000_0020, '0);
        chk("both_readback", v_data, 128'h1);
        chk("both_rd2",      128'(rd_count), 128'd2);

        // out-of-range read
        run_txn(1'b0, 1'b1, 32'h0000_1000, '0);
        chk("oor_rd_pulse",   128'(n_valid), 128'd1);
        chk("oor_rd_data",    v_data, 128'd0);
        chk("oor_rd_addrerr", 128'(addr_error), 128'd1);
        chk("oor_rd_err",     128'(err_count), 128'd2);
        chk("oor_rd_count",   128'(rd_count), 128'd3);

        // index 255 survives an out-of-range write aliasing onto it
        run_txn(1'b1, 1'b0, 32'h0000_0FF0, D_B);
        chk("hold_rdata_after_wr", mem_read_data, 128'd0);
        run_txn(1'b1, 1'b0, 32'hFFFF_FFF0, D_C);
        chk("oor_wr_err", 128'(err_count), 128'd3);
        chk("oor_wr_wr",  128'(wr_count), 128'd4);
        run_txn(1'b0, 1'b1, 32'h0000_0FF0, '0);
        chk("oor_wr_no_store", v_data, D_B);
        chk("oor_rd_count4",   128'(rd_count), 128'd4);

        // read enable held for 20 edges: one acceptance per 4 cycles
        rd_base = rd_count;
        pulses  = 0;
        mem_addr_bus    = 32'h0000_0010;
        mem_read_enable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk_main_200mhz);
            @(negedge clk_main_200mhz);
            if (mem_read_valid) pulses++;
        end
        mem_read_enable = 1'b0;
        repeat (2) begin
            @(negedge clk_main_200mhz);
            if (mem_read_valid) pulses++;
        end
        chk("sustain_reads",  128'(rd_count - rd_base), 128'd5);
        chk("sustain_pulses", 128'(pulses), 128'd5);
        chk("sustain_data",   mem_read_data, D_A);

        // reset during cycle 1 of a read drops the response
        mem_addr_bus    = 32'h0000_0010;
        mem_read_enable = 1'b1;
        @(posedge clk_main_200mhz);
        #1;
        mem_read_enable = 1'b0;
        @(negedge clk_main_200mhz);
        chk("midrst_busy", 128'(mem_ready), 128'd0);
        reset_n = 1'b0;
        #1;
        chk("midrst_ready_async", 128'(mem_ready), 128'd1);
        pulses = 0;
        repeat (2) begin
            @(negedge clk_main_200mhz);
            if (mem_read_valid) pulses++;
        end
        reset_n = 1'b1;
        repeat (4) begin
            @(negedge clk_main_200mhz);
            if (mem_read_valid) pulses++;
        end
        chk("midrst_no_pulse", 128'(pulses), 128'd0);
        chk("midrst_ready",    128'(mem_ready), 128'd1);
        chk("midrst_rd",       128'(rd_count), 128'd0);

        // error counter saturation, preloaded close to the limit
        force dut.r_err_count = 16'hFFFD;
        @(posedge clk_main_200mhz);
        @(negedge clk_main_200mhz);
        release dut.r_err_count;
        @(negedge clk_main_200mhz);
        chk("sat_preload", 128'(err_count), 128'hFFFD);
        run_txn(1'b0, 1'b1, 32'h0000_1000, '0);
        chk("sat_fffe", 128'(err_count), 128'hFFFE);
        run_txn(1'b0, 1'b1, 32'h0000_1000, '0);
        chk("sat_ffff", 128'(err_count), 128'hFFFF);
        run_txn(1'b0, 1'b1, 32'h0000_2000, '0);
        chk("sat_hold1", 128'(err_count), 128'hFFFF);
        run_txn(1'b1, 1'b1, 32'hFFFF_FFF0, D_C);
        chk("sat_hold2", 128'(err_count), 128'hFFFF);
        chk("sat_wr",    128'(wr_count), 128'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
